// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and defaults for the program loader
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int         DEPTH_DEFAULT     = 32;
  localparam logic [7:0] END_INSTR_DEFAULT = 8'b11000011;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_ram.sv
// rtl/instr_ram.sv - instruction store, one write port and one registered read port
module instr_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Contents are deliberately not reset; the loader gates reads with prog_len.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader feeding a fetch port; LOADER_CHECKSUM_EN adds a checksum output
module program_loader
  import loader_pkg::*;
#(
  parameter int         DEPTH     = DEPTH_DEFAULT,
  parameter logic [7:0] END_INSTR = END_INSTR_DEFAULT
) (
  input  logic       origclk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] pc,
  output logic [7:0] instruction,
  output logic       cpu_run,
  output logic [8:0] prog_len,
  output logic       load_err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam int            AW        = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [8:0]    FULL_LEN  = 9'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [8:0]    len_nxt;
  logic          err_nxt;
  logic          accept;
  logic          wr_en;
  logic          hit_q;
  logic [7:0]    rd_data;

  assign load_ready = (state == ST_LOAD);
  assign cpu_run    = (state == ST_RUN);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    len_nxt   = prog_len;
    err_nxt   = load_err;
    wr_en     = 1'b0;
    // A restart request outranks any byte offered in the same cycle.
    if (load_start) begin
      state_nxt = ST_LOAD;
      ptr_nxt   = '0;
      len_nxt   = '0;
      err_nxt   = 1'b0;
    end else if (accept) begin
      wr_en   = 1'b1;
      ptr_nxt = ptr + 1'b1;
      if (load_last) begin
        state_nxt = ST_RUN;
        len_nxt   = 9'(ptr) + 9'd1;
      end else if (ptr == LAST_ADDR) begin
        state_nxt = ST_RUN;
        len_nxt   = FULL_LEN;
        err_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      prog_len <= '0;
      load_err <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      prog_len <= len_nxt;
      load_err <= err_nxt;
      // Full-width compare so addresses past the store never alias.
      hit_q    <= (state == ST_RUN) && ({1'b0, pc} < prog_len);
    end
  end

  assign instruction = hit_q ? rd_data : END_INSTR;

  instr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (origclk),
    .we    (wr_en),
    .waddr (ptr),
    .wdata (load_data),
    .raddr (pc[AW-1:0]),
    .rdata (rd_data)
  );

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (load_start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + load_data;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized bench for program_loader against a queue-based reference model
module tb_program_loader;

  localparam int         DEPTH = 32;
  localparam logic [7:0] END_I = 8'hC3;
  localparam int         M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

  logic       origclk = 1'b0;
  logic       reset;
  logic       load_start, load_valid, load_last;
  logic [7:0] load_data, pc;
  logic       load_ready, cpu_run, load_err;
  logic [7:0] instruction;
  logic [8:0] prog_len;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  int         m_mode = M_IDLE;
  logic [7:0] m_prog[$];
  int         m_len = 0;
  bit         m_err = 1'b0;
  logic [7:0] m_instr = END_I;
  logic [7:0] m_sum = 8'h00;

  always #5 origclk = ~origclk;

  program_loader #(.DEPTH(DEPTH), .END_INSTR(END_I)) dut (
    .origclk     (origclk),
    .reset       (reset),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .pc          (pc),
    .instruction (instruction),
    .cpu_run     (cpu_run),
    .prog_len    (prog_len),
    .load_err    (load_err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_prog.delete();
    m_len = 0;
    m_err = 1'b0;
    m_instr = END_I;
    m_sum = 8'h00;
  endtask

  // One rising edge of the reference: fetch uses the pre-edge program view.
  task automatic model_edge();
    if (m_mode == M_RUN && int'(pc) < m_len) m_instr = m_prog[pc];
    else m_instr = END_I;
    if (load_start) begin
      m_mode = M_LOAD;
      m_prog.delete();
      m_len = 0;
      m_err = 1'b0;
      m_sum = 8'h00;
    end else if (m_mode == M_LOAD && load_valid) begin
      m_prog.push_back(load_data);
      m_sum = m_sum + load_data;
      if (load_last) begin
        m_mode = M_RUN;
        m_len = m_prog.size();
      end else if (m_prog.size() == DEPTH) begin
        m_mode = M_RUN;
        m_len = DEPTH;
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"}, load_ready, (m_mode == M_LOAD));
    check({tag, ".run"}, cpu_run, (m_mode == M_RUN));
    check({tag, ".len"}, prog_len, m_len);
    check({tag, ".err"}, load_err, m_err);
    check({tag, ".instr"}, instruction, m_instr);
`ifdef LOADER_CHECKSUM_EN
    check({tag, ".csum"}, checksum, m_sum);
`endif
  endtask

  task automatic set_in(input logic s, input logic v, input logic [7:0] d, input logic l, input logic [7:0] p);
    load_start = s;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    pc         = p;
  endtask

  task automatic step(input string tag);
    @(posedge origclk);
    model_edge();
    @(negedge origclk);
    check_all(tag);
  endtask

  // Called at a falling edge; reset drops mid-cycle, away from any rising edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all({tag, ".async"});
    check({tag, ".async_instr"}, instruction, 8'hC3);
    @(posedge origclk);
    @(negedge origclk);
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    repeat (2) @(negedge origclk);
    model_reset();
    check_all("reset");
    reset = 1'b1;

    set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); step("d1.start");
    set_in(1'b0, 1'b1, 8'hC3, 1'b0, 8'h00); step("d1.b0");
    set_in(1'b0, 1'b1, 8'h44, 1'b0, 8'h00); step("d1.b1");
    set_in(1'b0, 1'b1, 8'h49, 1'b1, 8'h00); step("d1.b2");
    check("d1.len3", prog_len, 9'd3);
    check("d1.run", cpu_run, 1'b1);
    check("d1.err0", load_err, 1'b0);

    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'd1);   step("d2.pc1");
    check("d2.pc1_val", instruction, 8'h44);
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'd3);   step("d2.pc3");
    check("d2.pc3_val", instruction, 8'hC3);
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'd200); step("d2.pc200");
    check("d2.pc200_val", instruction, 8'hC3);
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'd2);   step("d2.pc2");
    check("d2.pc2_val", instruction, 8'h49);

    set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); step("d3.start");
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, 1'b1, 8'($urandom), 1'b0, 8'($urandom_range(0, 40)));
      step("d3.byte");
    end
    check("d3.ready0", load_ready, 1'b0);
    check("d3.err1", load_err, 1'b1);
    check("d3.len32", prog_len, 9'd32);
    check("d3.run1", cpu_run, 1'b1);
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'($urandom_range(28, 36)));
      step("d3.fetch");
    end

    set_in(1'b1, 1'b1, 8'h55, 1'b0, 8'h00); step("d4.start_valid");
    check("d4.run0", cpu_run, 1'b0);
    check("d4.len0", prog_len, 9'd0);
    set_in(1'b0, 1'b1, 8'h11, 1'b1, 8'h00); step("d4.b0");
    set_in(1'b0, 1'b0, 8'h00, 1'b0, 8'h00); step("d4.fetch0");
    check("d4.first_byte", instruction, 8'h11);

    set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); step("d5.start");
    set_in(1'b0, 1'b1, 8'hA1, 1'b0, 8'h00); step("d5.b0");
    set_in(1'b0, 1'b1, 8'hA2, 1'b0, 8'h00); step("d5.b1");
    async_reset("d5");
    set_in(1'b0, 1'b1, 8'hA3, 1'b1, 8'h00); step("d5.ignored");

    set_in(1'b1, 1'b0, 8'h00, 1'b0, 8'h00); step("d6.start");
    set_in(1'b0, 1'b1, 8'hF0, 1'b0, 8'h00); step("d6.b0");
    set_in(1'b0, 1'b1, 8'h20, 1'b1, 8'h00); step("d6.b1");
`ifdef LOADER_CHECKSUM_EN
    check("d6.csum10", checksum, 8'h10);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] p;
      p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, DEPTH + 2));
      set_in(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, 8'($urandom),
             ($urandom_range(0, 9) == 0), p);
      step("rnd");
      if ($urandom_range(0, 499) == 0) async_reset("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning instruction store size in bytes (power of two, 2..256).
REQ-002 SHALL have parameter END_INSTR, default 8'b11000011, meaning the instruction returned for any address not holding a loaded byte.
REQ-003 SHALL have port origclk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset; low clears all state immediately.
REQ-005 SHALL have port load_start, input, 1: single-cycle request to begin a new program load.
REQ-006 SHALL have port load_valid, input, 1: load_data holds a program byte.
REQ-007 SHALL have port load_data, input, 8: program byte.
REQ-008 SHALL have port load_last, input, 1: qualifies the accepted byte as the final one.
REQ-009 SHALL have port load_ready, output, 1: loader can accept a byte this cycle.
REQ-010 SHALL have port pc, input, 8: fetch address from the processor.
REQ-011 SHALL have port instruction, output, 8: registered instruction byte for pc.
REQ-012 SHALL have port cpu_run, output, 1: high only in RUN; gates the processor's execution.
REQ-013 SHALL have port prog_len, output, 9: number of bytes in the current program.
REQ-014 SHALL have port load_err, output, 1: sticky overflow flag for the current program.

Function
REQ-015 SHALL implement the states IDLE, LOAD and RUN.
REQ-016 SHALL leave IDLE or RUN for LOAD on load_start; on entry, write pointer = 0, prog_len = 0 and load_err = 0.
REQ-017 SHALL drive load_ready high only in LOAD; a byte SHALL be accepted when load_valid and load_ready are both high.
REQ-018 SHALL write an accepted byte to mem[ptr] and increment ptr by 1.
REQ-019 SHALL, on an accepted byte with load_last high, go to RUN in the next cycle with prog_len = ptr+1.
REQ-020 SHALL, on an accepted byte at ptr = DEPTH-1 with load_last low, go to RUN with prog_len = DEPTH and load_err = 1.
REQ-021 SHALL let load_start win when it coincides with an accepted byte: the byte is discarded and the pointer restarts at 0.
REQ-022 SHALL hold cpu_run = 1 exactly in RUN; cpu_run SHALL fall in the cycle after load_start is sampled in RUN.
REQ-023 SHALL register instruction with 1-cycle latency: instruction(t+1) = mem[pc(t)] if pc(t) < prog_len, else END_INSTR.
REQ-024 SHALL output END_INSTR in IDLE and LOAD regardless of pc.
REQ-025 SHALL compare pc at full 8-bit width; pc >= DEPTH SHALL return END_INSTR with no wrap-around.

Reset
REQ-026 SHALL, while reset is low: state = IDLE, instruction = END_INSTR, cpu_run = 0, load_ready = 0, prog_len = 0, load_err = 0, ptr = 0.
REQ-027 SHALL not reset memory contents; they are unreachable because prog_len = 0.
REQ-028 SHALL, on reset during LOAD, abandon the partial program.

Configuration
REQ-029 SHALL, with LOADER_CHECKSUM_EN defined, add output checksum[7:0]: the modulo-256 sum of bytes accepted since the last LOAD entry, cleared on reset and on load_start.
REQ-030 SHALL, without LOADER_CHECKSUM_EN, have no checksum port and no checksum logic.

Structure
REQ-031 SHALL keep the state encoding, END_INSTR default and DEPTH default in the shared package loader_pkg.
REQ-032 SHALL implement storage as one sub-module, instr_ram: 1 write port, 1 registered read port.

Verification
REQ-033 Reset, then load C3,44,49 with last on 49 -> prog_len=3, cpu_run=1 the following cycle, load_err=0.
REQ-034 In RUN, pc=1 -> instruction=8'h44 one cycle later; pc=3 -> 8'hC3; pc=200 -> 8'hC3.
REQ-035 Load 32 bytes with load_last never high -> after the 32nd byte load_ready=0, load_err=1, prog_len=32, cpu_run=1.
REQ-036 load_start in RUN together with load_valid -> cpu_run=0 next cycle, no byte written, prog_len=0.
REQ-037 Assert reset mid-LOAD after 2 bytes -> all outputs at reset values asynchronously, state IDLE, instruction=8'hC3.
REQ-038 With LOADER_CHECKSUM_EN, load 8'hF0, 8'h20 -> checksum=8'h10.
